// File: rtl/rob_queue.sv
// Reorder buffer: in-order allocate and commit, out-of-order writeback,
// operand query with same-cycle writeback bypass, and flush on a mispredict.
module rob_queue #(
  parameter int DEPTH  = 16,
  parameter int NO_TAG = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          dc_valid,
  input  logic [4:0]    dc_rd,
  input  logic          dc_is_br,
  output logic          full,
  output logic [AW-1:0] rob_en,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_tag,
  input  logic [31:0]   wb_val,
  input  logic          wb_mispred,
  input  logic [31:0]   wb_target,
  input  logic [AW-1:0] qj_tag,
  input  logic [AW-1:0] qk_tag,
  output logic          qj_ok,
  output logic          qk_ok,
  output logic [31:0]   vj,
  output logic [31:0]   vk,
  output logic          commit,
  output logic [AW-1:0] commit_tag,
  output logic [31:0]   commit_val,
  output logic [4:0]    commit_rd,
  output logic          clear,
  output logic [31:0]   clear_pc
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] NO_TAG_W = (AW+1)'(NO_TAG);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] is_br;
  logic [DEPTH-1:0] mispred;
  logic [4:0]       rd_q  [DEPTH];
  logic [31:0]      val_q [DEPTH];
  logic [31:0]      tgt_q [DEPTH];

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count;

  logic full_r;
  logic alloc;
  logic wb_hit;
  logic do_commit;
  logic do_clear;
  logic qj_hit;
  logic qk_hit;

  // Handshake decisions; full is taken from the registered count only.
  always_comb begin
    full_r    = (count == FULL_CNT);
    do_commit = ~rst & rdy & busy[head] & ready[head];
    do_clear  = do_commit & is_br[head] & mispred[head];
    alloc     = ~rst & rdy & dc_valid & ~full_r & ~do_clear;
    wb_hit    = ~rst & rdy & wb_valid & busy[wb_tag];
  end

  // Retire port, flush request and allocation tag.
  always_comb begin
    full       = ~rst & full_r;
    rob_en     = rst ? '0 : tail;
    commit     = do_commit;
    commit_tag = do_commit ? head : '0;
    commit_val = do_commit ? val_q[head] : '0;
    commit_rd  = do_commit ? rd_q[head] : '0;
    clear      = do_clear;
    clear_pc   = do_clear ? tgt_q[head] : '0;
  end

  // Operand lookup: stored result first, else the writeback in flight.
  always_comb begin
    qj_ok  = 1'b0;
    qk_ok  = 1'b0;
    vj     = '0;
    vk     = '0;
    qj_hit = ~rst & ({1'b0, qj_tag} != NO_TAG_W) & busy[qj_tag];
    qk_hit = ~rst & ({1'b0, qk_tag} != NO_TAG_W) & busy[qk_tag];
    if (qj_hit && ready[qj_tag]) begin
      qj_ok = 1'b1;
      vj    = val_q[qj_tag];
    end else if (qj_hit && wb_valid && wb_tag == qj_tag) begin
      qj_ok = 1'b1;
      vj    = wb_val;
    end
    if (qk_hit && ready[qk_tag]) begin
      qk_ok = 1'b1;
      vk    = val_q[qk_tag];
    end else if (qk_hit && wb_valid && wb_tag == qk_tag) begin
      qk_ok = 1'b1;
      vk    = wb_val;
    end
  end

  // Entry status flags and queue pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= '0;
      ready   <= '0;
      is_br   <= '0;
      mispred <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
    end else if (do_clear) begin
      busy  <= '0;
      ready <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (alloc) begin
        busy[tail]    <= 1'b1;
        ready[tail]   <= 1'b0;
        mispred[tail] <= 1'b0;
        is_br[tail]   <= dc_is_br;
        tail          <= tail + AW'(1);
      end
      if (wb_hit) begin
        ready[wb_tag]   <= 1'b1;
        mispred[wb_tag] <= wb_mispred;
      end
      if (do_commit) begin
        busy[head]  <= 1'b0;
        ready[head] <= 1'b0;
        head        <= head + AW'(1);
      end
      if (alloc && !do_commit)
        count <= count + (AW+1)'(1);
      else if (!alloc && do_commit)
        count <= count - (AW+1)'(1);
    end
  end

  // Entry payload; only meaningful while the entry is busy.
  always_ff @(posedge clk) begin
    if (alloc)
      rd_q[tail] <= dc_rd;
    if (wb_hit) begin
      val_q[wb_tag] <= wb_val;
      tgt_q[wb_tag] <= wb_target;
    end
  end

endmodule

// File: tb/tb_rob_queue.sv
// Directed bench for rob_queue with a commit scoreboard.
// Issued entries are queued; commits are popped and compared.
module tb_rob_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        dc_valid;
  logic [4:0]  dc_rd;
  logic        dc_is_br;
  logic        full;
  logic [3:0]  rob_en;
  logic        wb_valid;
  logic [3:0]  wb_tag;
  logic [31:0] wb_val;
  logic        wb_mispred;
  logic [31:0] wb_target;
  logic [3:0]  qj_tag;
  logic [3:0]  qk_tag;
  logic        qj_ok;
  logic        qk_ok;
  logic [31:0] vj;
  logic [31:0] vk;
  logic        commit;
  logic [3:0]  commit_tag;
  logic [31:0] commit_val;
  logic [4:0]  commit_rd;
  logic        clear;
  logic [31:0] clear_pc;

  rob_queue dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .dc_valid   (dc_valid),
    .dc_rd      (dc_rd),
    .dc_is_br   (dc_is_br),
    .full       (full),
    .rob_en     (rob_en),
    .wb_valid   (wb_valid),
    .wb_tag     (wb_tag),
    .wb_val     (wb_val),
    .wb_mispred (wb_mispred),
    .wb_target  (wb_target),
    .qj_tag     (qj_tag),
    .qk_tag     (qk_tag),
    .qj_ok      (qj_ok),
    .qk_ok      (qk_ok),
    .vj         (vj),
    .vk         (vk),
    .commit     (commit),
    .commit_tag (commit_tag),
    .commit_val (commit_val),
    .commit_rd  (commit_rd),
    .clear      (clear),
    .clear_pc   (clear_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] tag;
    logic [4:0] rd;
  } sb_t;

  sb_t         sbq [$];
  logic [31:0] wbv [16];
  logic [3:0]  mt;
  int          checks = 0;
  int          fails  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic exp_commit(input string tag);
    sb_t e;
    chk({tag, "_commit"}, {31'd0, commit}, 32'd1);
    checks++;
    assert (sbq.size() > 0) else begin
      fails++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({tag, "_tag"}, {28'd0, commit_tag}, {28'd0, e.tag});
      chk({tag, "_rd"}, {27'd0, commit_rd}, {27'd0, e.rd});
      chk({tag, "_val"}, commit_val, wbv[e.tag]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rdy = 1'b1;
    dc_valid = 1'b0;
    wb_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    sbq.delete();
    mt = '0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic br);
    dc_valid = 1'b1;
    dc_rd    = rd;
    dc_is_br = br;
    #1;
    chk("rob_en", {28'd0, rob_en}, {28'd0, mt});
    sbq.push_back('{tag: mt, rd: rd});
    tick();
    mt++;
    dc_valid = 1'b0;
    dc_is_br = 1'b0;
  endtask

  task automatic wb(input logic [3:0] t, input logic [31:0] v,
                    input logic mis, input logic [31:0] tg);
    wb_valid   = 1'b1;
    wb_tag     = t;
    wb_val     = v;
    wb_mispred = mis;
    wb_target  = tg;
    wbv[t]     = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; dc_valid = 1'b0; dc_rd = '0; dc_is_br = 1'b0;
    wb_valid = 1'b0; wb_tag = '0; wb_val = '0; wb_mispred = 1'b0;
    wb_target = '0; qj_tag = '0; qk_tag = '0; mt = '0;
    for (int i = 0; i < 16; i++) wbv[i] = '0;

    tick();
    tick();
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_rob_en", {28'd0, rob_en}, 32'd0);
    chk("rst_commit", {31'd0, commit}, 32'd0);
    chk("rst_clear", {31'd0, clear}, 32'd0);
    chk("rst_clear_pc", clear_pc, 32'd0);
    chk("rst_qj_ok", {31'd0, qj_ok}, 32'd0);
    chk("rst_qk_ok", {31'd0, qk_ok}, 32'd0);
    chk("rst_commit_val", commit_val, 32'd0);
    do_reset();

    // single issue, writeback, commit
    issue(5'd5, 1'b0);
    wb(4'd0, 32'h1234, 1'b0, 32'h0);
    #1;
    chk("basic_pre_commit", {31'd0, commit}, 32'd0);
    tick();
    wb_valid = 1'b0;
    #1;
    exp_commit("basic");
    tick();
    chk("basic_after", {31'd0, commit}, 32'd0);
    chk("basic_commit_val0", commit_val, 32'd0);

    // fill to full, refused issue, commit while full
    do_reset();
    for (int i = 0; i < 16; i++) issue(5'(i + 1), 1'b0);
    chk("fill_full", {31'd0, full}, 32'd1);
    dc_valid = 1'b1;
    dc_rd = 5'd31;
    #1;
    chk("fill_rob_en_wrap", {28'd0, rob_en}, 32'd0);
    tick();
    chk("fill_refused_tail", {28'd0, rob_en}, 32'd0);
    chk("fill_still_full", {31'd0, full}, 32'd1);
    wb(4'd0, 32'h50, 1'b0, 32'h0);
    tick();
    wb_valid = 1'b0;
    #1;
    exp_commit("fullc");
    chk("fullc_full", {31'd0, full}, 32'd1);
    tick();
    dc_valid = 1'b0;
    #1;
    chk("fullc_not_full", {31'd0, full}, 32'd0);
    chk("fullc_tail", {28'd0, rob_en}, 32'd0);

    // operand query and bypass
    do_reset();
    for (int i = 0; i < 4; i++) issue(5'(i + 1), 1'b0);
    qj_tag = 4'd3;
    qk_tag = 4'd2;
    #1;
    chk("q_notready", {31'd0, qj_ok}, 32'd0);
    wb(4'd3, 32'hAB, 1'b0, 32'h0);
    #1;
    chk("q_byp_ok", {31'd0, qj_ok}, 32'd1);
    chk("q_byp_vj", vj, 32'hAB);
    chk("q_k_ok", {31'd0, qk_ok}, 32'd0);
    chk("q_k_v", vk, 32'd0);
    tick();
    wb_valid = 1'b0;
    qk_tag = 4'd5;
    #1;
    chk("q_stored_ok", {31'd0, qj_ok}, 32'd1);
    chk("q_stored_vj", vj, 32'hAB);
    chk("q_idle_ok", {31'd0, qk_ok}, 32'd0);

    // out-of-order writeback, in-order commit
    wb(4'd1, 32'h11, 1'b0, 32'h0);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("ooo_wait", {31'd0, commit}, 32'd0);
    wb(4'd0, 32'h10, 1'b0, 32'h0);
    #1;
    chk("ooo_wait2", {31'd0, commit}, 32'd0);
    tick();
    wb_valid = 1'b0;
    #1;
    exp_commit("ooo0");
    tick();
    exp_commit("ooo1");
    tick();
    chk("ooo_stall", {31'd0, commit}, 32'd0);
    wb(4'd2, 32'h22, 1'b0, 32'h0);
    tick();
    wb_valid = 1'b0;
    #1;
    exp_commit("ooo2");
    tick();
    exp_commit("ooo3");
    tick();
    chk("ooo_empty", {31'd0, commit}, 32'd0);

    // mispredicted branch flush
    do_reset();
    issue(5'd0, 1'b1);
    issue(5'd7, 1'b0);
    wb(4'd0, 32'h4, 1'b1, 32'h100);
    tick();
    wb_valid = 1'b0;
    #1;
    dc_valid = 1'b1;
    dc_rd = 5'd2;
    wb(4'd1, 32'h77, 1'b0, 32'h0);
    #1;
    exp_commit("br");
    chk("br_clear", {31'd0, clear}, 32'd1);
    chk("br_clear_pc", clear_pc, 32'h100);
    tick();
    dc_valid = 1'b0;
    wb_valid = 1'b0;
    sbq.delete();
    mt = '0;
    qj_tag = 4'd1;
    qk_tag = 4'd0;
    #1;
    chk("fl_rob_en", {28'd0, rob_en}, 32'd0);
    chk("fl_full", {31'd0, full}, 32'd0);
    chk("fl_commit", {31'd0, commit}, 32'd0);
    chk("fl_clear_pc", clear_pc, 32'd0);
    chk("fl_qj", {31'd0, qj_ok}, 32'd0);
    chk("fl_qk", {31'd0, qk_ok}, 32'd0);
    wb(4'd1, 32'h55, 1'b0, 32'h0);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("fl_wb_ignored", {31'd0, commit}, 32'd0);

    // global enable low freezes everything
    do_reset();
    issue(5'd9, 1'b0);
    wb(4'd0, 32'h99, 1'b0, 32'h0);
    tick();
    wb_valid = 1'b0;
    rdy = 1'b0;
    dc_valid = 1'b1;
    dc_rd = 5'd3;
    #1;
    chk("rdy0_commit", {31'd0, commit}, 32'd0);
    tick();
    chk("rdy0_commit2", {31'd0, commit}, 32'd0);
    chk("rdy0_tail", {28'd0, rob_en}, 32'd1);
    dc_valid = 1'b0;
    rdy = 1'b1;
    #1;
    exp_commit("rdy1");
    tick();

    // reset mid-operation, then writeback into an empty queue
    issue(5'd4, 1'b0);
    rst = 1'b1;
    dc_valid = 1'b1;
    wb(4'd1, 32'h66, 1'b0, 32'h0);
    tick();
    #1;
    chk("mid_rst_rob_en", {28'd0, rob_en}, 32'd0);
    chk("mid_rst_commit", {31'd0, commit}, 32'd0);
    rst = 1'b0;
    dc_valid = 1'b0;
    wb_valid = 1'b0;
    sbq.delete();
    mt = '0;
    tick();
    chk("post_rst_rob_en", {28'd0, rob_en}, 32'd0);
    wb(4'd0, 32'h77, 1'b0, 32'h0);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("empty_wb", {31'd0, commit}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/rob_queue.md
ROB_QUEUE -- requirements
Module: rob_queue

Interface
REQ-001 The parameter DEPTH, default 16, SHALL set the number of entries (power of two; tags are 4 bits).
REQ-002 The parameter NO_TAG, default 16, SHALL be the 5-bit "no dependency" tag value, never used as an entry tag.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 rdy  in  1  global enable; when low, all state SHALL hold and commit/clear SHALL be 0.
REQ-006 dc_valid  in  1  decoder issues one instruction this cycle.
REQ-007 dc_rd  in  5  destination register of the issued instruction (0 = none).
REQ-008 dc_is_br  in  1  issued instruction is a branch/jump whose misprediction flushes.
REQ-009 full  out  1  no free entry; issue SHALL be refused.
REQ-010 rob_en  out  4  tag allocated to the instruction issued this cycle (= tail pointer).
REQ-011 wb_valid, wb_tag[3:0], wb_val[31:0], wb_mispred, wb_target[31:0]  in  writeback bus from execution units.
REQ-012 qj_tag, qk_tag  in  4 each  operand tags queried by the register file.
REQ-013 qj_ok, qk_ok  out  1 each; vj, vk  out  32 each  operand-ready flag and value.
REQ-014 commit  out  1; commit_tag  out  4; commit_val  out  32; commit_rd  out  5  retiring entry.
REQ-015 clear  out  1; clear_pc  out  32  flush request and redirect target.

Function
REQ-016 State: per entry busy, ready, rd[4:0], val[31:0], is_br, mispred, target[31:0]; head[3:0], tail[3:0], count[4:0].
REQ-017 full SHALL equal (count == DEPTH), from registered count only.
REQ-018 Allocation: when rdy & dc_valid & !full & !clear, entry[tail] SHALL become busy=1, ready=0, mispred=0, rd/is_br captured; tail SHALL increment mod DEPTH.
REQ-019 Writeback: when rdy & wb_valid & entry[wb_tag].busy, that entry SHALL set ready=1, val=wb_val, mispred=wb_mispred, target=wb_target; writeback to a non-busy entry SHALL be ignored.
REQ-020 Query (combinational): qj_ok SHALL be 1 when entry[qj_tag] is busy and ready (vj = its val), or when wb_valid & wb_tag==qj_tag & entry busy (vj = wb_val, same-cycle bypass); else qj_ok=0, vj=0. Same for qk.
REQ-021 Commit (combinational, one per cycle): commit = rdy & entry[head].busy & entry[head].ready; commit_tag=head, commit_val/commit_rd from entry[head]; when commit=0, commit_val/commit_rd/commit_tag SHALL be 0.
REQ-022 On commit the head entry SHALL be freed (busy=0) and head SHALL increment mod DEPTH at the same edge.
REQ-023 count SHALL be +1 on allocate only, -1 on commit only, unchanged on both or neither.
REQ-024 clear = commit & entry[head].is_br & entry[head].mispred; clear_pc = entry[head].target when clear, else 0.
REQ-025 On clear all entries SHALL become non-busy, head=tail=count=0; same-cycle allocation and writeback SHALL be discarded.
REQ-026 Full and committing in the same cycle: allocation SHALL still be refused (full is registered).
REQ-027 Empty (count==0): commit SHALL be 0; writeback with any tag SHALL be ignored.
REQ-028 Pointer wrap: tail/head at DEPTH-1 SHALL wrap to 0.

Reset
REQ-029 On rst: all entries busy=0, ready=0; head=tail=count=0; full=0, rob_en=0, commit=0, commit_tag/val/rd=0, clear=0, clear_pc=0, qj_ok=qk_ok=0.
REQ-030 rst SHALL override rdy, allocation, writeback and commit in the same cycle, including mid-operation.

Verification
REQ-031 Reset, issue rd=5 -> rob_en=0; wb tag0 val=0x1234 -> next cycle commit=1, commit_rd=5, commit_val=0x1234, commit_tag=0.
REQ-032 Issue 16 instrs, no wb -> full=1 after 16th; 17th dc_valid refused, tail stays 0; wb tag0 -> commit, count=15, full=0 next cycle.
REQ-033 Query qj_tag=3 while wb_valid tag3 val=0xAB same cycle -> qj_ok=1, vj=0xAB; non-ready entry -> qj_ok=0, vj=0.
REQ-034 Out-of-order wb (tag1 before tag0) -> no commit until tag0 ready, then commits tag0 and tag1 on consecutive cycles.
REQ-035 Branch at head, wb_mispred=1 target=0x100, dc_valid same cycle -> clear=1, clear_pc=0x100; next cycle count=0, rob_en=0, no busy entries.
REQ-036 rdy=0 with pending ready head -> commit=0, state frozen; rdy=1 -> commit resumes.
